sort_loader: RTL and testbench
==============================

# sort_loader

Upstream feeder for the 8-input byte sorter. Accepts a stream of 8-bit values over a valid/ready handshake, packs them into eight parallel slots, and presents a stable 8-lane frame to the combinational sorter's `n1`..`n8` inputs. The frame is held until the downstream consumer acknowledges it. Short frames are padded so that unused lanes sort to a known position.

## Interface
- `PAD`, default `8'hFF`: value written into unfilled lanes of a short frame.
- `clk  in  1`: rising-edge clock.
- `rst_n  in  1`: reset, asynchronous and active-low. The block has one clock.
- `in_valid  in  1`: an input byte is offered.
- `in_ready  out  1`: the loader can accept a byte.
- `in_data  in  8`: the input byte.
- `in_last  in  1`: the offered byte is the final byte of its frame. Used only when `SORT_LOADER_PAD_EN` is defined.
- `n1`..`n8`  out  8 each: frame lanes in arrival order. `n1` is the first byte accepted.
- `frame_valid  out  1`: the lanes hold a complete frame.
- `frame_ready  in  1`: the consumer has taken the frame.
- `frame_count  out  4`: number of real (non-pad) bytes in the current frame, 1..8.
- `frame_id  out  8`: sequence number of the presented frame.

## Operation
- The block has two states, FILL and FULL.
- **FILL**
  - `in_ready`=1 and `frame_valid`=0.
  - A beat occurs when `in_valid && in_ready`. On a beat, `in_data` is written to the lane at the write index `idx` (0..7), and `idx` increments.
  - The frame closes on the beat where `idx`==7, or on a beat with `in_last`=1 (pad build only). When the frame closes, the state moves to FULL.
  - On a closing `in_last` beat, all lanes above the current index are written with `PAD` at the same clock edge.
  - `frame_count` is set to `idx`+1 of the closing beat.
- **FULL**
  - `in_ready`=0, `frame_valid`=1.
  - Lanes, `frame_count` and `frame_id` are stable.
  - When `frame_ready`=1: the state moves to FILL, `idx` is set to 0, and `frame_id` increments modulo 256 (255 wraps to 0).
  - Lanes keep their old values after the handshake until they are overwritten by the next frame.
- `in_last` is ignored unless a beat occurs.
- `in_last` on the 8th beat closes the frame normally, with no pad lanes.
- Frames never overlap. `in_ready` is a pure function of the state, with no combinational path from `frame_ready`.

## Timing
- Reset values: state=FILL, `idx`=0, all lanes=`8'h00`, `frame_valid`=0, `in_ready`=1, `frame_count`=0, `frame_id`=0.
- Reset is asynchronous. Asserting it mid-frame discards any partially filled or presented frame immediately.
- Latency:
  - `frame_valid` rises on the first clock edge after the closing beat.
  - A full frame takes 8 beats, so `frame_valid` is high 8 cycles after the first beat when `in_valid` is held continuously.
- Handshake:
  - `frame_valid` falls on the edge where `frame_ready`=1 is sampled in FULL.
  - `in_ready` rises at that same edge.
  - The minimum gap between frames is 1 cycle (the acknowledge cycle).
- `frame_ready` asserted while in FILL has no effect.
- Outputs are registered, except `in_ready`, which is decoded from the state register.

## Configuration
- Macro: `SORT_LOADER_PAD_EN`.
- **Defined:** `in_last` closes short frames. Unfilled lanes are set to `PAD`, and `frame_count` reflects the real byte count.
- **Undefined:** `in_last` is not connected internally and its input is ignored. Frames close only after 8 beats, `frame_count` is always 8 when `frame_valid`=1, and the `PAD` logic is removed.

## Test plan
- **Reset state:** hold `rst_n`=0, release it, and sample before any beat. Required: `in_ready`=1, `frame_valid`=0, all lanes 0, `frame_id`=0.
- **Full frame:** stream 5, 12, 255, 1, 0, 12, 19, 68 on consecutive cycles, with `frame_ready`=0. Required:
  - `n1`..`n8` = 5, 12, 255, 1, 0, 12, 19, 68, and `frame_count`=8.
  - `frame_valid`=1 one cycle after the 8th beat, and `in_ready`=0.
  - The frame is held stable for 5 idle cycles.
- **Short frame (pad build):** send 7, 3, 9, with `in_last` on the byte 9. Required: lanes = 7, 3, 9, FF, FF, FF, FF, FF, `frame_count`=3, and `frame_valid` the next cycle.
- **Acknowledge and frame_id wrap:** run 256 frames, acknowledging each with a 1-cycle `frame_ready` pulse. Required:
  - `frame_id` counts 0 through 255 and returns to 0.
  - `in_ready` rises on the same edge at which `frame_valid` falls.
- **Stalls and reset mid-frame:**
  - Toggle `in_valid` randomly. Required: only beats are captured, in order.
  - Assert `rst_n`=0 after 4 beats. Required: all outputs return to their reset values asynchronously, and the next frame starts at lane `n1`.

Source files
------------

// File: rtl/sort_loader_if.sv
// Stream-in / frame-out bundle for the sorter's upstream loader.
//   in_valid/in_ready/in_data/in_last : byte stream into the loader
//   n1..n8                            : frame lanes, n1 = first byte accepted
//   frame_valid/frame_ready           : frame handshake to the consumer
//   frame_count/frame_id              : real byte count and frame sequence number
// master = producer/consumer side, slave = loader side.
interface sort_loader_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic [7:0] n1, n2, n3, n4, n5, n6, n7, n8;
  logic       frame_valid;
  logic       frame_ready;
  logic [3:0] frame_count;
  logic [7:0] frame_id;

  modport master (
    output in_valid, in_data, in_last, frame_ready,
    input  in_ready, n1, n2, n3, n4, n5, n6, n7, n8,
           frame_valid, frame_count, frame_id
  );

  modport slave (
    input  in_valid, in_data, in_last, frame_ready,
    output in_ready, n1, n2, n3, n4, n5, n6, n7, n8,
           frame_valid, frame_count, frame_id
  );
endinterface

// File: rtl/sort_loader.sv
// sort_loader: packs a byte stream into an 8-lane frame for the byte sorter
// and holds it until the consumer acknowledges it.
// Ports: clk, rst_n (async, active-low), bus (sort_loader_if.slave).
// Parameter PAD: fill value for unused lanes of a short frame.
// Build option SORT_LOADER_PAD_EN: when defined, in_last closes short frames
// and pads the remaining lanes; otherwise frames always hold 8 bytes.
module sort_loader #(
  parameter logic [7:0] PAD = 8'hFF
) (
  input  logic          clk,
  input  logic          rst_n,
  sort_loader_if.slave  bus
);

  localparam int unsigned NLANES = 8;
  localparam int unsigned DW     = 8;
  localparam int unsigned IW     = 3;
  localparam int unsigned CW     = 4;
  localparam int unsigned FW     = 8;

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   lane_q [NLANES];
  logic [DW-1:0]   lane_d [NLANES];
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   count_q, count_d;
  logic [FW-1:0]   id_q, id_d;
  logic            last_c;
  logic            beat_c;
  logic            close_c;
  logic            ack_c;

`ifdef SORT_LOADER_PAD_EN
  assign last_c = bus.in_last;
`else
  logic                  unused_in_last;
  localparam logic [DW-1:0] unused_pad = PAD;
  assign unused_in_last = bus.in_last;
  assign last_c         = 1'b0;
`endif

  assign beat_c  = bus.in_valid && (state_q == FILL);
  assign close_c = beat_c && ((idx_q == IW'(NLANES - 1)) || last_c);
  assign ack_c   = (state_q == FULL) && bus.frame_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FILL;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (close_c) state_d = FULL;
      FULL:    if (bus.frame_ready) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Handshake outputs decoded straight from the state flop
  always_comb begin
    bus.in_ready    = 1'b0;
    bus.frame_valid = 1'b0;
    if (state_q == FILL) bus.in_ready    = 1'b1;
    else                 bus.frame_valid = 1'b1;
  end

  // Lane, index, count and id updates
  always_comb begin
    for (int i = 0; i < NLANES; i++) lane_d[i] = lane_q[i];
    idx_d   = idx_q;
    count_d = count_q;
    id_d    = id_q;
    if (beat_c) begin
      lane_d[idx_q] = bus.in_data;
      idx_d         = idx_q + IW'(1);
      if (close_c) begin
        idx_d   = '0;
        count_d = CW'(idx_q) + CW'(1);
`ifdef SORT_LOADER_PAD_EN
        // Lanes beyond the closing byte get PAD so they sort to a known spot
        if (last_c) begin
          for (int i = 0; i < NLANES; i++) begin
            if (IW'(i) > idx_q) lane_d[i] = PAD;
          end
        end
`endif
      end
    end
    if (ack_c) begin
      idx_d = '0;
      id_d  = id_q + FW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NLANES; i++) lane_q[i] <= '0;
      idx_q   <= '0;
      count_q <= '0;
      id_q    <= '0;
    end else begin
      for (int i = 0; i < NLANES; i++) lane_q[i] <= lane_d[i];
      idx_q   <= idx_d;
      count_q <= count_d;
      id_q    <= id_d;
    end
  end

  assign bus.n1          = lane_q[0];
  assign bus.n2          = lane_q[1];
  assign bus.n3          = lane_q[2];
  assign bus.n4          = lane_q[3];
  assign bus.n5          = lane_q[4];
  assign bus.n6          = lane_q[5];
  assign bus.n7          = lane_q[6];
  assign bus.n8          = lane_q[7];
  assign bus.frame_count = count_q;
  assign bus.frame_id    = id_q;

endmodule

// File: tb/tb_sort_loader.sv
// Directed bench for sort_loader: reset, full frame, short frame / in_last,
// acknowledge timing, stalls, async reset mid-frame and frame_id wrap.
module tb_sort_loader;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic [7:0] exp_id;

  sort_loader_if bus ();

  sort_loader #(.PAD(8'hFF)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] lanes();
    return {bus.n1, bus.n2, bus.n3, bus.n4, bus.n5, bus.n6, bus.n7, bus.n8};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 8'hEE;
  endtask

  // One-cycle acknowledge; in_ready must rise on the same edge frame_valid falls
  task automatic ack(input string tag);
    chk({tag, "_pre_rdy"}, 64'(bus.in_ready), 64'd0);
    chk({tag, "_pre_fv"}, 64'(bus.frame_valid), 64'd1);
    bus.frame_ready = 1'b1;
    tick();
    bus.frame_ready = 1'b0;
    exp_id = exp_id + 8'd1;
    chk({tag, "_post_fv"}, 64'(bus.frame_valid), 64'd0);
    chk({tag, "_post_rdy"}, 64'(bus.in_ready), 64'd1);
    chk({tag, "_id"}, 64'(bus.frame_id), 64'(exp_id));
  endtask

  initial begin
    logic [63:0] exp_l;
    logic [63:0] hold_l;
    int          k;
    n_checks        = 0;
    n_errors        = 0;
    exp_id          = 8'd0;
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_data     = 8'h00;
    bus.in_last     = 1'b0;
    bus.frame_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_fv", 64'(bus.frame_valid), 64'd0);
    chk("rst_lanes", lanes(), 64'd0);
    chk("rst_id", 64'(bus.frame_id), 64'd0);
    chk("rst_count", 64'(bus.frame_count), 64'd0);

    // Full frame on consecutive cycles
    beat(8'd5, 1'b0);   beat(8'd12, 1'b0); beat(8'd255, 1'b0); beat(8'd1, 1'b0);
    beat(8'd0, 1'b0);   beat(8'd12, 1'b0); beat(8'd19, 1'b0);
    chk("full_fv_early", 64'(bus.frame_valid), 64'd0);
    beat(8'd68, 1'b0);
    chk("full_fv", 64'(bus.frame_valid), 64'd1);
    chk("full_rdy", 64'(bus.in_ready), 64'd0);
    chk("full_lanes", lanes(), 64'h050C_FF01_000C_1344);
    chk("full_count", 64'(bus.frame_count), 64'd8);
    chk("full_id", 64'(bus.frame_id), 64'd0);
    // Offered bytes while FULL must not be taken
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_lanes", lanes(), 64'h050C_FF01_000C_1344);
      chk("hold_fv", 64'(bus.frame_valid), 64'd1);
    end
    bus.in_valid = 1'b0;
    ack("ack0");
    chk("ack0_lanes_kept", lanes(), 64'h050C_FF01_000C_1344);

    // frame_ready while filling does nothing
    bus.frame_ready = 1'b1;
    tick();
    bus.frame_ready = 1'b0;
    chk("fill_rdy_id", 64'(bus.frame_id), 64'(exp_id));
    chk("fill_rdy_fv", 64'(bus.frame_valid), 64'd0);

`ifdef SORT_LOADER_PAD_EN
    // Short frame closed by in_last
    beat(8'd7, 1'b0); beat(8'd3, 1'b0); beat(8'd9, 1'b1);
    chk("short_fv", 64'(bus.frame_valid), 64'd1);
    chk("short_lanes", lanes(), 64'h0703_09FF_FFFF_FFFF);
    chk("short_count", 64'(bus.frame_count), 64'd3);
    ack("ack_short");
    // in_last on the 8th byte: normal full frame
    for (int i = 0; i < 7; i++) beat(8'(8'h10 + i), 1'b0);
    beat(8'h17, 1'b1);
    chk("last8_lanes", lanes(), 64'h1011_1213_1415_1617);
    chk("last8_count", 64'(bus.frame_count), 64'd8);
    ack("ack_last8");
`else
    // in_last is ignored: frame only closes after 8 bytes
    beat(8'd7, 1'b0); beat(8'd3, 1'b0); beat(8'd9, 1'b1);
    chk("nopad_fv", 64'(bus.frame_valid), 64'd0);
    for (int i = 1; i <= 5; i++) beat(8'(i), 1'b0);
    chk("nopad_fv8", 64'(bus.frame_valid), 64'd1);
    chk("nopad_lanes", lanes(), 64'h0703_0901_0203_0405);
    chk("nopad_count", 64'(bus.frame_count), 64'd8);
    ack("ack_nopad");
`endif

    // Random stalls: only accepted beats land, in order
    k = 0;
    exp_l = '0;
    for (int c = 0; c < 200 && k < 8; c++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = bus.in_valid ? 8'(8'h31 + 8'(k * 17)) : 8'hEE;
      if (bus.in_valid) begin
        exp_l = {exp_l[55:0], 8'(8'h31 + 8'(k * 17))};
        k++;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    chk("stall_beats", 64'(k), 64'd8);
    chk("stall_lanes", lanes(), exp_l);
    ack("ack_stall");

    // Async reset after 4 beats
    for (int i = 0; i < 4; i++) beat(8'(8'h51 + i), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rdy", 64'(bus.in_ready), 64'd1);
    chk("arst_fv", 64'(bus.frame_valid), 64'd0);
    chk("arst_lanes", lanes(), 64'd0);
    chk("arst_id", 64'(bus.frame_id), 64'd0);
    chk("arst_count", 64'(bus.frame_count), 64'd0);
    exp_id = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) beat(8'(8'hA0 + i), 1'b0);
    chk("post_rst_lanes", lanes(), 64'hA0A1_A2A3_A4A5_A6A7);
    chk("post_rst_id", 64'(bus.frame_id), 64'd0);
    ack("ack_post_rst");

    // 256 acknowledged frames: frame_id walks through 255 and wraps to 0
    for (int f = 0; f < 256; f++) begin
      exp_l = '0;
      for (int i = 0; i < 8; i++) begin
        hold_l[7:0] = 8'(f) ^ 8'(i * 29);
        exp_l = {exp_l[55:0], hold_l[7:0]};
        beat(hold_l[7:0], 1'b0);
      end
      chk("wrap_lanes", lanes(), exp_l);
      chk("wrap_id", 64'(bus.frame_id), 64'(exp_id));
      ack("wrap_ack");
    end
    chk("wrap_final_id", 64'(bus.frame_id), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
